// File: rtl/gpu_sched_pkg.sv
// Shared types for the raster scheduler: vertex/triangle payloads and FSM encoding.
package gpu_sched_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;

  // One vertex: [2]=x, [1]=y, [0]=z, each IEEE-754 single.
  typedef logic [2:0][31:0] vertex_t;

  typedef struct packed {
    vertex_t p1;
    vertex_t p2;
    vertex_t p3;
    logic    last;
  } tri_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRAIN = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  localparam int TRI_W = $bits(tri_t);

endpackage

// File: rtl/raster_scheduler_if.sv
// Triangle source -> scheduler valid/ready channel.
interface raster_scheduler_if;
  logic                 tri_valid;
  logic                 tri_ready;
  logic                 tri_last;
  gpu_sched_pkg::vertex_t tri_p1;
  gpu_sched_pkg::vertex_t tri_p2;
  gpu_sched_pkg::vertex_t tri_p3;

  modport master (output tri_valid, tri_last, tri_p1, tri_p2, tri_p3, input tri_ready);
  modport slave  (input tri_valid, tri_last, tri_p1, tri_p2, tri_p3, output tri_ready);
endinterface

// File: rtl/raster_scheduler_tri_fifo.sv
// Synchronous triangle FIFO; ready is registered so it never depends on push/pop combinationally.
module tri_fifo
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic areset_n,
  input  logic push,
  input  tri_t din,
  input  logic pop,
  output tri_t dout,
  output logic ready,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  tri_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; simultaneous push+pop nets to zero.
  always_comb begin
    count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  // Storage is not reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, count and registered ready flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Frame sequencer: optional clear sweep, then issues queued triangles to the rasterizer.
module raster_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_W       = 640,
  parameter int FB_H       = 480
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               frame_go,
  input  logic               clear_en,
  input  logic [COLOR_W-1:0] clear_color,
  raster_scheduler_if.slave  tri_in,
  output logic               ru_start,
  output vertex_t            ru_p1,
  output vertex_t            ru_p2,
  output vertex_t            ru_p3,
  input  logic               ru_done,
  input  logic [COORD_W-1:0] ru_fb_x,
  input  logic [COORD_W-1:0] ru_fb_y,
  input  logic [COLOR_W-1:0] ru_data,
  input  logic               ru_fb_we,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        tri_count
);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CLEAR = CLEAR;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_ISSUE = ISSUE;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_DONE  = DONE;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_H - 1);

  logic [2:0]         state, state_nxt;
  logic [COORD_W-1:0] cx, cy;
  logic [COLOR_W-1:0] color_q;
  logic               last_q;
  logic               fifo_empty;
  logic               job_done;
  logic               frame_start;
  tri_t               fifo_din, fifo_head;

  assign fifo_din    = '{p1: tri_in.tri_p1, p2: tri_in.tri_p2, p3: tri_in.tri_p3, last: tri_in.tri_last};
  assign frame_start = (state == S_IDLE) && frame_go;
  // ru_start marks the first WAIT cycle; done is only believed after it.
  assign job_done    = (state == S_WAIT) && !ru_start && ru_done;
  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_DONE);

  tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (tri_in.tri_valid),
    .din      (fifo_din),
    .pop      (state == S_ISSUE),
    .dout     (fifo_head),
    .ready    (tri_in.tri_ready),
    .empty    (fifo_empty)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_go) state_nxt = clear_en ? S_CLEAR : S_DRAIN;
      S_CLEAR: if (cx == X_MAX && cy == Y_MAX) state_nxt = S_DRAIN;
      S_DRAIN: if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (job_done) state_nxt = last_q ? S_DONE : S_DRAIN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Clear sweeper: raster-order coordinates and latched colour.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cx      <= '0;
      cy      <= '0;
      color_q <= '0;
    end else if (frame_start) begin
      cx      <= '0;
      cy      <= '0;
      color_q <= clear_color;
    end else if (state == S_CLEAR) begin
      if (cx == X_MAX) begin
        cx <= '0;
        if (cy != Y_MAX) cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Rasterizer job registers: vertices held from ISSUE until the next ISSUE.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ru_start <= 1'b0;
      ru_p1    <= '0;
      ru_p2    <= '0;
      ru_p3    <= '0;
      last_q   <= 1'b0;
    end else begin
      ru_start <= (state == S_ISSUE);
      if (state == S_ISSUE) begin
        ru_p1  <= fifo_head.p1;
        ru_p2  <= fifo_head.p2;
        ru_p3  <= fifo_head.p3;
        last_q <= fifo_head.last;
      end
    end
  end

  // Per-frame completed-triangle counter, saturating.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)                         tri_count <= '0;
    else if (frame_start)                  tri_count <= '0;
    else if (job_done && tri_count != '1)  tri_count <= tri_count + 1'b1;
  end

  // Frame-buffer write port: sweeper owns it during CLEAR, rasterizer otherwise.
  always_comb begin
    fb_x    = ru_fb_x;
    fb_y    = ru_fb_y;
    fb_data = ru_data;
    fb_we   = ru_fb_we;
    if (state == S_CLEAR) begin
      fb_x    = cx;
      fb_y    = cy;
      fb_data = color_q;
      fb_we   = 1'b1;
    end
  end

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler with a 4x2 frame buffer.
module tb_raster_scheduler;
  import gpu_sched_pkg::*;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic         frame_go = 1'b0, clear_en = 1'b0;
  logic [3:0]   clear_color = '0;
  logic         ru_start, ru_done = 1'b0, ru_fb_we = 1'b0;
  vertex_t      ru_p1, ru_p2, ru_p3;
  logic [9:0]   ru_fb_x = '0, ru_fb_y = '0, fb_x, fb_y;
  logic [3:0]   ru_data = '0, fb_data;
  logic         fb_we, busy, frame_done;
  logic [15:0]  tri_count;
  int           checks = 0, errors = 0;

  raster_scheduler_if tri_bus();

  raster_scheduler #(.FIFO_DEPTH(8), .FB_W(4), .FB_H(2)) dut (
    .clk(clk), .areset_n(areset_n), .frame_go(frame_go), .clear_en(clear_en),
    .clear_color(clear_color), .tri_in(tri_bus), .ru_start(ru_start),
    .ru_p1(ru_p1), .ru_p2(ru_p2), .ru_p3(ru_p3), .ru_done(ru_done),
    .ru_fb_x(ru_fb_x), .ru_fb_y(ru_fb_y), .ru_data(ru_data), .ru_fb_we(ru_fb_we),
    .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .frame_done(frame_done), .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  localparam logic [95:0] VA1 = {32'h428a0000, 32'h428a0000, 32'h3f800000};
  localparam logic [95:0] VB1 = {32'h40000000, 32'h40400000, 32'h3f800000};
  localparam logic [95:0] VC1 = {32'h41000000, 32'h41100000, 32'h00000000};

  function automatic logic [95:0] vtx(input int i);
    return {i[31:0], 32'h0, 32'h3f800000};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [95:0] p1, input logic last);
    tri_bus.tri_valid = 1'b1;
    tri_bus.tri_p1    = p1;
    tri_bus.tri_p2    = ~p1;
    tri_bus.tri_p3    = {p1[63:0], p1[95:64]};
    tri_bus.tri_last  = last;
    tick();
    tri_bus.tri_valid = 1'b0;
  endtask

  initial begin
    tri_bus.tri_valid = 1'b0;
    tri_bus.tri_last  = 1'b0;
    tri_bus.tri_p1 = '0; tri_bus.tri_p2 = '0; tri_bus.tri_p3 = '0;

    // Reset state
    tick(); tick();
    areset_n = 1'b1;
    chk("rst_ready", tri_bus.tri_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_count", tri_count, 0);
    chk("rst_start", ru_start, 0);
    chk("rst_p1",    ru_p1, 0);

    // frame_go with empty FIFO parks in DRAIN
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk("empty_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_nostart", ru_start, 0);
    end
    areset_n = 1'b0; tick(); areset_n = 1'b1;
    chk("rst2_busy", busy, 0);

    // Two preloaded triangles, no clear
    push(VA1, 1'b0);
    push(VB1, 1'b1);
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk("f1_c1_start", ru_start, 0);
    tick();
    chk("f1_c2_start", ru_start, 0);
    tick();
    chk("f1_c3_start", ru_start, 1);
    chk("f1_p1", ru_p1, VA1);
    chk("f1_p2", ru_p2, ~VA1);
    repeat (10) tick();
    chk("f1_start_low", ru_start, 0);
    chk("f1_p1_hold", ru_p1, VA1);
    ru_done = 1'b1; tick(); ru_done = 1'b0;
    chk("f1_cnt1", tri_count, 1);
    chk("f1_nodone", frame_done, 0);
    tick(); tick();
    chk("f1_start2", ru_start, 1);
    chk("f1_p1b", ru_p1, VB1);
    // done held on the start cycle, plus a stray frame_go
    ru_done = 1'b1; frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk("f1_done_ign_cnt", tri_count, 1);
    chk("f1_done_ign_fd", frame_done, 0);
    chk("f1_done_ign_busy", busy, 1);
    tick(); ru_done = 1'b0;
    chk("f1_frame_done", frame_done, 1);
    chk("f1_cnt2", tri_count, 2);
    tick();
    chk("f1_fd_pulse", frame_done, 0);
    chk("f1_idle", busy, 0);
    chk("f1_cnt_hold", tri_count, 2);
    tick();
    chk("f1_go_ignored", busy, 0);

    // Clear sweep 4x2 with colour A; rasterizer writes blocked
    ru_fb_we = 1'b1; ru_fb_x = 10'd5; ru_fb_y = 10'd7; ru_data = 4'h3;
    clear_en = 1'b1; clear_color = 4'hA; frame_go = 1'b1;
    tick();
    frame_go = 1'b0; clear_en = 1'b0; clear_color = 4'h0;
    chk("clr_count0", tri_count, 0);
    for (int i = 0; i < 8; i++) begin
      chk("clr_we", fb_we, 1);
      chk("clr_x", fb_x, i % 4);
      chk("clr_y", fb_y, i / 4);
      chk("clr_data", fb_data, 4'hA);
      tick();
    end
    chk("clr_pass_x", fb_x, 10'd5);
    chk("clr_pass_we", fb_we, 1);
    ru_fb_we = 1'b0; #1;
    chk("clr_pass_we0", fb_we, 0);
    chk("clr_drain_busy", busy, 1);
    push(VC1, 1'b1);
    tick(); tick();
    chk("clr_start", ru_start, 1);
    chk("clr_p1", ru_p1, VC1);
    ru_done = 1'b1; tick(); tick(); ru_done = 1'b0;
    chk("clr_fd", frame_done, 1);
    chk("clr_cnt", tri_count, 1);
    tick();
    chk("clr_idle", busy, 0);

    // Fill FIFO to depth
    for (int i = 0; i < 8; i++) begin
      tri_bus.tri_valid = 1'b1;
      tri_bus.tri_p1 = vtx(i);
      tri_bus.tri_last = 1'b0;
      tick();
      chk("fill_ready", tri_bus.tri_ready, (i < 7) ? 1'b1 : 1'b0);
    end
    tri_bus.tri_valid = 1'b0;
    tick();
    chk("full_hold", tri_bus.tri_ready, 0);
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    tick(); tick();
    chk("pop_ready", tri_bus.tri_ready, 1);
    chk("pop_p1", ru_p1, vtx(0));
    ru_done = 1'b1; tick(); tick(); ru_done = 1'b0;
    chk("fill_cnt1", tri_count, 1);
    tick();
    // ISSUE cycle at count 7: push and pop together
    tri_bus.tri_valid = 1'b1; tri_bus.tri_p1 = vtx(8);
    tick();
    tri_bus.tri_valid = 1'b0;
    chk("pp_ready", tri_bus.tri_ready, 1);
    chk("pp_p1", ru_p1, vtx(1));
    chk("pp_start", ru_start, 1);
    tri_bus.tri_valid = 1'b1; tri_bus.tri_p1 = vtx(9);
    tick();
    tri_bus.tri_valid = 1'b0;
    chk("pp_full_again", tri_bus.tri_ready, 0);

    // Reset mid-WAIT with a full queue
    areset_n = 1'b0; #1;
    chk("mid_rst_ready", tri_bus.tri_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", ru_start, 0);
    chk("mid_rst_p1", ru_p1, 0);
    chk("mid_rst_cnt", tri_count, 0);
    chk("mid_rst_we", fb_we, 0);
    tick(); tick();
    chk("mid_rst_fd", frame_done, 0);
    areset_n = 1'b1;
    tick();
    chk("mid_rst_fd2", frame_done, 0);
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_empty", ru_start, 0);
      chk("post_rst_busy", busy, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
